rv_fetch_decode_ctrl: RTL and testbench

Upstream control stage for the Datapath (register file + ALU) block. Holds a small loadable instruction memory and a program counter. A multi-cycle FSM fetches and decodes RV32I R-type instructions and drives `read_reg_num1`, `read_reg_num2`, `write_reg`, `alu_control` and `regwrite` into Datapath. It samples Datapath's `zero_flag` back as status.

---
 rtl/rv_fetch_decode_ctrl.sv | 112 +++++++++++
 tb/tb_rv_fetch_decode_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_decode_ctrl.sv
// rv_fetch_decode_ctrl: multi-cycle RV32I R-type fetch/decode FSM driving Datapath.
// Optional RETIRE_CNT_EN adds a 32-bit retire_count output.
module rv_fetch_decode_ctrl #(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_wdata,
  input  logic            zero_flag,
  output logic [4:0]      read_reg_num1,
  output logic [4:0]      read_reg_num2,
  output logic [4:0]      write_reg,
  output logic [3:0]      alu_control,
  output logic            regwrite,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            last_zero
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_count
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  state_t state;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] instr;
  logic [3:0] alu_dec;
  logic legal;
  logic idle_or_halt;
  assign idle_or_halt = state == IDLE || state == HALT;
  assign busy = state == FETCH || state == DECODE || state == EXEC;
  assign halted = state == HALT;
  always_ff @(posedge clock)
    if (imem_we && idle_or_halt) imem[imem_addr] <= imem_wdata;
  always_comb begin
    legal = instr[6:0] == 7'b0110011;
    alu_dec = 4'b0000;
    case ({instr[31:25], instr[14:12]})
      {7'b0000000, 3'b000}: alu_dec = 4'b0010;
      {7'b0100000, 3'b000}: alu_dec = 4'b0110;
      {7'b0000000, 3'b111}: alu_dec = 4'b0000;
      {7'b0000000, 3'b110}: alu_dec = 4'b0001;
      {7'b0000000, 3'b100}: alu_dec = 4'b0100;
      {7'b0000000, 3'b001}: alu_dec = 4'b1000;
      {7'b0000000, 3'b101}: alu_dec = 4'b1001;
      {7'b0100000, 3'b101}: alu_dec = 4'b1010;
      {7'b0000000, 3'b010}: alu_dec = 4'b0111;
      {7'b0000000, 3'b011}: alu_dec = 4'b1011;
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      instr <= '0;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg <= '0;
      alu_control <= '0;
      regwrite <= 1'b0;
      illegal <= 1'b0;
      last_zero <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          pc <= '0;
        end
        FETCH: begin
          instr <= imem[pc];
          state <= DECODE;
        end
        DECODE: if (legal) begin
          read_reg_num1 <= instr[19:15];
          read_reg_num2 <= instr[24:20];
          write_reg <= instr[11:7];
          alu_control <= alu_dec;
          // regwrite is high for the whole EXEC cycle; x0 destinations never pulse
          regwrite <= instr[11:7] != 5'd0;
          state <= EXEC;
        end else begin
          illegal <= instr != 32'h0000_0073;
          state <= HALT;
        end
        EXEC: begin
          last_zero <= zero_flag;
          pc <= pc + 1'b1;
          state <= FETCH;
        end
        HALT: if (start) begin
          state <= FETCH;
          pc <= '0;
          illegal <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef RETIRE_CNT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) retire_count <= '0;
    else if (start && idle_or_halt) retire_count <= '0;
    else if (state == EXEC) retire_count <= retire_count + 32'd1;
`endif
endmodule

// File: tb/tb_rv_fetch_decode_ctrl.sv
// tb_rv_fetch_decode_ctrl: scoreboard bench; a program-level reference model predicts
// every regwrite pulse and halt, and a negedge monitor compares them as they appear.
module tb_rv_fetch_decode_ctrl;
  localparam int D = 64;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [13:0] OPS [10] = '{
    {7'b0000000, 3'b000, 4'b0010}, {7'b0100000, 3'b000, 4'b0110},
    {7'b0000000, 3'b111, 4'b0000}, {7'b0000000, 3'b110, 4'b0001},
    {7'b0000000, 3'b100, 4'b0100}, {7'b0000000, 3'b001, 4'b1000},
    {7'b0000000, 3'b101, 4'b1001}, {7'b0100000, 3'b101, 4'b1010},
    {7'b0000000, 3'b010, 4'b0111}, {7'b0000000, 3'b011, 4'b1011}};
  logic clock = 0, reset = 1, start = 0, imem_we = 0, zero_flag = 0;
  logic [5:0] imem_addr = 0;
  logic [31:0] imem_wdata = 0;
  logic [4:0] read_reg_num1, read_reg_num2, write_reg;
  logic [3:0] alu_control;
  logic regwrite, busy, halted, illegal, last_zero;
  logic [5:0] pc;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif
  typedef struct {
    bit is_halt;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] alu;
    logic [5:0] pc;
    bit ill;
    int unsigned ret;
  } ev_t;
  ev_t exp_q[$];
  logic [31:0] m [D];
  int checks = 0, errors = 0;
  bit force_zero = 0;
  always #5 clock = ~clock;
  rv_fetch_decode_ctrl #(.IMEM_DEPTH(D), .PC_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .zero_flag(zero_flag),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal),
    .last_zero(last_zero)
`ifdef RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );
  function automatic bit ref_dec(input logic [31:0] w, output logic [3:0] alu);
    logic [13:0] op;
    alu = 4'b0;
    if (w[6:0] != 7'b0110011) return 1'b0;
    for (int i = 0; i < 10; i++) begin
      op = OPS[i];
      if (op[13:4] == {w[31:25], w[14:12]}) begin
        alu = op[3:0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction
  task automatic run_model(input int limit);
    int p;
    int unsigned r;
    logic [3:0] a;
    logic [31:0] w;
    ev_t e;
    p = 0;
    r = 0;
    for (int n = 0; n < limit; n++) begin
      w = m[p];
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
      e.pc = p[5:0]; e.ret = r;
      if (ref_dec(w, a)) begin
        e.is_halt = 0; e.alu = a; e.ill = 0;
        if (w[11:7] != 5'd0) exp_q.push_back(e);
        r++;
        p = (p + 1) % D;
      end else begin
        e.is_halt = 1; e.alu = 4'b0; e.ill = w != ECALL;
        exp_q.push_back(e);
        return;
      end
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
    zero_flag = force_zero ? 1'b1 : 1'($urandom_range(0, 1));
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    imem_we = 1; imem_addr = a[5:0]; imem_wdata = d; m[a] = d;
    tick;
    imem_we = 0;
  endtask
  task automatic go(input int limit);
    run_model(limit);
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !halted) && n < 3000) begin
      tick;
      n++;
    end
    chk("wait_done_timeout", 64'(n >= 3000), 64'd0);
    exp_q.delete();
  endtask
  function automatic logic [31:0] rand_legal();
    logic [13:0] op;
    logic [31:0] r;
    op = OPS[$urandom_range(0, 9)];
    r = $urandom;
    return {op[13:7], r[24:15], op[6:4], r[11:7], 7'b0110011};
  endfunction
  function automatic logic [31:0] rand_term();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return ECALL;
      1: return {r[31:7], 7'h13};
      2: return {7'h01, r[24:0]} & 32'hFFFF_FF80 | 32'h33;
      default: return {7'h20, r[24:15], 3'b001, r[11:7], 7'h33};
    endcase
  endfunction
  bit prev_h = 0, lz_pend = 0, lz_exp = 0;
  always @(negedge clock) begin
    ev_t e;
    logic [63:0] act, ex;
    if (lz_pend && reset) begin
      checks++;
      if (last_zero !== lz_exp) begin
        errors++;
        $display("FAIL last_zero got %b expected %b", last_zero, lz_exp);
      end
    end
    lz_pend = 0;
    if (regwrite === 1'b1) begin
      lz_pend = 1;
      lz_exp = zero_flag;
      checks++;
      if (exp_q.size() == 0 || exp_q[0].is_halt) begin
        errors++;
        $display("FAIL regwrite unexpected pulse rd=%0d pc=%0d expected none", write_reg, pc);
      end else begin
        e = exp_q.pop_front();
        act = {read_reg_num1, read_reg_num2, write_reg, alu_control, pc};
        ex = {e.rs1, e.rs2, e.rd, e.alu, e.pc};
        if (act !== ex) begin
          errors++;
          $display("FAIL regwrite fields got %0h expected %0h", act, ex);
        end
      end
    end
    if (halted === 1'b1 && !prev_h) begin
      checks++;
      if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
        errors++;
        $display("FAIL halt unexpected at pc=%0d expected a regwrite or nothing", pc);
      end else begin
        e = exp_q.pop_front();
`ifdef RETIRE_CNT_EN
        act = {illegal, pc, retire_count};
        ex = {e.ill, e.pc, 32'(e.ret)};
`else
        act = {illegal, pc};
        ex = {e.ill, e.pc};
`endif
        if (act !== ex) begin
          errors++;
          $display("FAIL halt status got %0h expected %0h", act, ex);
        end
      end
    end
    prev_h = halted === 1'b1;
  end
  initial begin
    int nb, n, len;
    logic [31:0] t;
    #2 reset = 0;
    tick;
    tick;
    chk("reset_state", {read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite,
                        pc, busy, halted, illegal, last_zero}, 64'd0);
    reset = 1;
    tick;
    for (int i = 0; i < D; i++) wr(i, ECALL);
    wr(0, 32'h002081B3);
    wr(1, ECALL);
    go(200);
    chk("t1_fetch_regwrite", regwrite, 0);
    tick;
    chk("t1_decode_regwrite", regwrite, 0);
    tick;
    chk("t1_exec_outputs", {regwrite, write_reg, alu_control, read_reg_num1, read_reg_num2},
        {1'b1, 5'd3, 4'b0010, 5'd1, 5'd2});
    wait_done;
    chk("t1_halt_status", {halted, illegal, pc}, {1'b1, 1'b0, 6'd1});
    force_zero = 1;
    wr(0, 32'h405282B3);
    go(200);
    wait_done;
    chk("t2_sub", {alu_control, last_zero}, {4'b0110, 1'b1});
    force_zero = 0;
    wr(0, 32'h00208033);
    go(200);
    wait_done;
    chk("t3_x0_halt", {halted, illegal, pc}, {1'b1, 1'b0, 6'd1});
`ifdef RETIRE_CNT_EN
    chk("t3_retire_count", retire_count, 1);
`endif
    wr(0, 32'h00000013);
    go(200);
    wait_done;
    chk("t4_illegal", {halted, illegal, pc}, {1'b1, 1'b1, 6'd0});
    wr(0, ECALL);
    go(200);
    chk("t4_illegal_cleared", {busy, illegal}, {1'b1, 1'b0});
    wait_done;
    for (int i = 0; i < D; i++) wr(i, 32'h002081B3);
    go(D + 5);
    nb = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick;
      if (!busy) nb++;
      n++;
    end
    chk("t5_wrap_timeout", 64'(n >= 1000), 64'd0);
    chk("t5_busy_low_cycles", nb, 0);
    tick;
    reset = 0;
    #1;
    chk("t6_reset_in_decode", {read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite,
                               pc, busy, halted, illegal, last_zero}, 64'd0);
    exp_q.delete();
    tick;
    reset = 1;
    tick;
    wr(1, ECALL);
    go(200);
    imem_we = 1; imem_addr = 6'd1; imem_wdata = 32'h00000013;
    tick;
    imem_we = 0;
    wait_done;
    chk("t6_imem_kept", {halted, illegal, pc}, {1'b1, 1'b0, 6'd1});
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) wr(i, rand_legal());
      t = rand_term();
      wr(len, t);
      go(200);
      imem_we = 1; imem_addr = 6'(len); imem_wdata = (t == ECALL) ? 32'h13 : ECALL;
      tick;
      imem_we = 0;
      wait_done;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
